// File: rtl/sysid_check_pkg.sv
// rtl/sysid_check_pkg.sv - shared types and constants for the sysid check sequencer
package sysid_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_RD_TS = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int MISMATCH_W = 8;
    localparam int SETTLE_W   = 4;

    function automatic logic state_is_busy(input state_e s);
        return (s == ST_RD_ID) || (s == ST_RD_TS) || (s == ST_CHECK);
    endfunction

    function automatic logic state_is_read(input state_e s);
        return (s == ST_RD_ID) || (s == ST_RD_TS);
    endfunction

endpackage

// File: rtl/sysid_settle_timer.sv
// rtl/sysid_settle_timer.sv - address settle counter, expires when count reaches SETTLE_CYCLES
module sysid_settle_timer
    import sysid_check_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [SETTLE_W-1:0] SETTLE_LIMIT = SETTLE_W'(SETTLE_CYCLES);

    logic [SETTLE_W-1:0] count_q;
    logic [SETTLE_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == SETTLE_LIMIT);

endmodule

// File: rtl/sysid_check_sequencer.sv
// rtl/sysid_check_sequencer.sv - reads sysid ID/timestamp words and publishes match status
module sysid_check_sequencer
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID   = 32'd0,
    parameter logic [31:0] EXPECTED_TS   = 32'd1530840655,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          AUTO_START    = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  sysid_address,
    output logic                  sysid_read,
    input  logic [31:0]           sysid_readdata,
    output logic                  busy,
    output logic                  done,
    output logic                  id_ok,
    output logic                  ts_ok,
    output logic [31:0]           id_value,
    output logic [31:0]           ts_value,
    output logic [MISMATCH_W-1:0] mismatch_count
);

    localparam logic [MISMATCH_W-1:0] MISMATCH_MAX = {MISMATCH_W{1'b1}};

    state_e                  state_q, state_d;
    logic                    auto_pending_q, auto_pending_d;
    logic                    sysid_address_q, sysid_address_d;
    logic                    sysid_read_q, sysid_read_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    id_ok_q, id_ok_d;
    logic                    ts_ok_q, ts_ok_d;
    logic [31:0]             id_value_q, id_value_d;
    logic [31:0]             ts_value_q, ts_value_d;
    logic [MISMATCH_W-1:0]   mismatch_count_q, mismatch_count_d;
    logic                    settle_expired;

    // Restarting the count on every state change keeps each read phase at SETTLE_CYCLES + 1 cycles.
    sysid_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_d != state_q),
        .enable  (state_is_read(state_q)),
        .expired (settle_expired)
    );

    always_comb begin
        state_d          = state_q;
        auto_pending_d   = auto_pending_q;
        id_ok_d          = id_ok_q;
        ts_ok_d          = ts_ok_q;
        id_value_d       = id_value_q;
        ts_value_d       = ts_value_q;
        mismatch_count_d = mismatch_count_q;

        case (state_q)
            ST_IDLE: begin
                if (start || auto_pending_q) begin
                    state_d = ST_RD_ID;
                end
            end
            ST_RD_ID: begin
                if (settle_expired) begin
                    id_value_d = sysid_readdata;
                    state_d    = ST_RD_TS;
                end
            end
            ST_RD_TS: begin
                if (settle_expired) begin
                    ts_value_d = sysid_readdata;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                id_ok_d = (id_value_q == EXPECTED_ID);
                ts_ok_d = (ts_value_q == EXPECTED_TS);
                if (((id_value_q != EXPECTED_ID) || (ts_value_q != EXPECTED_TS)) &&
                    (mismatch_count_q != MISMATCH_MAX)) begin
                    mismatch_count_d = mismatch_count_q + 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    state_d = ST_RD_ID;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_RD_ID) begin
            auto_pending_d = 1'b0;
        end

        // Outputs are registered from the next state so they line up with the state they describe.
        busy_d          = state_is_busy(state_d);
        done_d          = (state_d == ST_DONE);
        sysid_read_d    = state_is_read(state_d);
        sysid_address_d = (state_d == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            auto_pending_q   <= AUTO_START;
            sysid_address_q  <= SYSID_ADDR_ID;
            sysid_read_q     <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            id_ok_q          <= 1'b0;
            ts_ok_q          <= 1'b0;
            id_value_q       <= '0;
            ts_value_q       <= '0;
            mismatch_count_q <= '0;
        end else begin
            state_q          <= state_d;
            auto_pending_q   <= auto_pending_d;
            sysid_address_q  <= sysid_address_d;
            sysid_read_q     <= sysid_read_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            id_ok_q          <= id_ok_d;
            ts_ok_q          <= ts_ok_d;
            id_value_q       <= id_value_d;
            ts_value_q       <= ts_value_d;
            mismatch_count_q <= mismatch_count_d;
        end
    end

    assign sysid_address  = sysid_address_q;
    assign sysid_read     = sysid_read_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign id_ok          = id_ok_q;
    assign ts_ok          = ts_ok_q;
    assign id_value       = id_value_q;
    assign ts_value       = ts_value_q;
    assign mismatch_count = mismatch_count_q;

endmodule

// File: tb/tb_sysid_check_sequencer.sv
// tb/tb_sysid_check_sequencer.sv - randomized self-checking bench for sysid_check_sequencer
module tb_sysid_check_sequencer;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1530840655;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_s [3];
    logic        start_s [3];
    logic [31:0] rd_s    [3];
    logic        addr_s  [3];
    logic        read_s  [3];
    logic        busy_s  [3];
    logic        done_s  [3];
    logic        idok_s  [3];
    logic        tsok_s  [3];
    logic [31:0] idv_s   [3];
    logic [31:0] tsv_s   [3];
    logic [7:0]  mis_s   [3];

    int checks   = 0;
    int failures = 0;
    int exp_mis [3];

    // Instance 0: settle 1, instance 1: settle 0, instance 2: settle 15.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        sysid_check_sequencer #(
            .EXPECTED_ID  (EXP_ID),
            .EXPECTED_TS  (EXP_TS),
            .SETTLE_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : 15),
            .AUTO_START   (1'b1)
        ) u_dut (
            .clock          (clock),
            .reset          (reset_s[g]),
            .start          (start_s[g]),
            .sysid_address  (addr_s[g]),
            .sysid_read     (read_s[g]),
            .sysid_readdata (rd_s[g]),
            .busy           (busy_s[g]),
            .done           (done_s[g]),
            .id_ok          (idok_s[g]),
            .ts_ok          (tsok_s[g]),
            .id_value       (idv_s[g]),
            .ts_value       (tsv_s[g]),
            .mismatch_count (mis_s[g])
        );
    end

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 15;
    endfunction

    function automatic logic [31:0] pick(input logic [31:0] good);
        return ($urandom_range(0, 1) == 0) ? good : $urandom();
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_zero(input int k);
        check_eq($sformatf("k%0d_rst_addr", k), addr_s[k], 0);
        check_eq($sformatf("k%0d_rst_read", k), read_s[k], 0);
        check_eq($sformatf("k%0d_rst_busy", k), busy_s[k], 0);
        check_eq($sformatf("k%0d_rst_done", k), done_s[k], 0);
        check_eq($sformatf("k%0d_rst_idok", k), idok_s[k], 0);
        check_eq($sformatf("k%0d_rst_tsok", k), tsok_s[k], 0);
        check_eq($sformatf("k%0d_rst_idv", k), idv_s[k], 0);
        check_eq($sformatf("k%0d_rst_tsv", k), tsv_s[k], 0);
        check_eq($sformatf("k%0d_rst_mis", k), mis_s[k], 0);
    endtask

    // Called in the cycle where start is offered (or cycle 0 after reset for the auto check).
    // Relative cycle i follows the timeline: read ID in 1..s+1, read TS in s+2..2s+2,
    // compare in 2s+3, done from 2s+4. Readdata is only correct on each phase's last cycle.
    task automatic run_check(input int k, input bit use_start, input bit hammer, input bit garble,
                             input logic [31:0] idw, input logic [31:0] tsw, input int abort_at);
        int s, fid, fts, done_at, last;
        bit fail;
        s       = settle_of(k);
        fid     = s + 1;
        fts     = 2 * s + 2;
        done_at = 2 * s + 4;
        last    = done_at + 1;
        fail    = (idw != EXP_ID) || (tsw != EXP_TS);
        for (int i = 0; i <= last; i++) begin
            if (i > 0) step();
            check_eq($sformatf("k%0d_c%0d_read", k, i), read_s[k], (i >= 1 && i <= fts) ? 1 : 0);
            check_eq($sformatf("k%0d_c%0d_addr", k, i), addr_s[k], (i >= s + 2 && i <= fts) ? 1 : 0);
            check_eq($sformatf("k%0d_c%0d_busy", k, i), busy_s[k], (i >= 1 && i < done_at) ? 1 : 0);
            if (i >= 1) begin
                check_eq($sformatf("k%0d_c%0d_done", k, i), done_s[k], (i >= done_at) ? 1 : 0);
                if (i == done_at && fail && exp_mis[k] < 255) exp_mis[k]++;
                if (i < done_at) begin
                    check_eq($sformatf("k%0d_c%0d_idok", k, i), idok_s[k], 0);
                    check_eq($sformatf("k%0d_c%0d_tsok", k, i), tsok_s[k], 0);
                end else begin
                    check_eq($sformatf("k%0d_c%0d_idok", k, i), idok_s[k], (idw == EXP_ID) ? 1 : 0);
                    check_eq($sformatf("k%0d_c%0d_tsok", k, i), tsok_s[k], (tsw == EXP_TS) ? 1 : 0);
                    check_eq($sformatf("k%0d_c%0d_idv", k, i), idv_s[k], idw);
                    check_eq($sformatf("k%0d_c%0d_tsv", k, i), tsv_s[k], tsw);
                    check_eq($sformatf("k%0d_c%0d_mis", k, i), mis_s[k], exp_mis[k]);
                end
            end
            if (i == abort_at) begin
                start_s[k] = 1'b0;
                reset_s[k] = 1'b1;
                step();
                check_zero(k);
                reset_s[k] = 1'b0;
                exp_mis[k] = 0;
                return;
            end
            start_s[k] = (i == 0 && use_start) || (hammer && i >= 1 && i < done_at);
            if (i == fid)      rd_s[k] = idw;
            else if (i == fts) rd_s[k] = tsw;
            else if (garble)   rd_s[k] = $urandom();
            else               rd_s[k] = (i <= fid) ? idw : tsw;
        end
        start_s[k] = 1'b0;
    endtask

    task automatic bring_up(input int k, input logic [31:0] idw, input logic [31:0] tsw);
        reset_s[k] = 1'b0;
        exp_mis[k] = 0;
        check_zero(k);
        run_check(k, 1'b0, 1'b0, 1'b1, idw, tsw, -1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            reset_s[k] = 1'b1;
            start_s[k] = 1'b0;
            rd_s[k]    = '0;
            exp_mis[k] = 0;
        end
        repeat (3) step();

        bring_up(0, EXP_ID, EXP_TS);
        run_check(0, 1'b1, 1'b0, 1'b1, EXP_ID, 32'h12345678, -1);
        check_eq("k0_ts_bad_count", mis_s[0], 1);
        run_check(0, 1'b1, 1'b1, 1'b1, pick(EXP_ID), pick(EXP_TS), -1);
        for (int n = 0; n < 6; n++) begin
            run_check(0, 1'b1, 1'b0, ($urandom_range(0, 1) == 1), pick(EXP_ID), pick(EXP_TS), -1);
        end
        run_check(0, 1'b1, 1'b0, 1'b1, $urandom(), $urandom(), 3);
        run_check(0, 1'b0, 1'b0, 1'b1, EXP_ID, EXP_TS, -1);

        bring_up(1, pick(EXP_ID), pick(EXP_TS));
        for (int n = 0; n < 4; n++) begin
            run_check(1, 1'b1, 1'b0, 1'b1, pick(EXP_ID), pick(EXP_TS), -1);
        end
        for (int n = 0; n < 260; n++) begin
            run_check(1, 1'b1, 1'b0, 1'b0, pick(EXP_ID), EXP_TS ^ (32'd1 << $urandom_range(0, 31)), -1);
        end
        check_eq("k1_saturated", mis_s[1], 255);
        run_check(1, 1'b1, 1'b0, 1'b0, EXP_ID, EXP_TS, -1);

        bring_up(2, pick(EXP_ID), pick(EXP_TS));
        run_check(2, 1'b1, 1'b1, 1'b1, pick(EXP_ID), pick(EXP_TS), -1);
        run_check(2, 1'b1, 1'b0, 1'b1, $urandom(), EXP_TS, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sysid_check_sequencer.md
# sysid_check_sequencer

Boot-time controller for the system-ID Avalon slave. After reset (and on each host request) it reads the slave's ID word (address 0) and timestamp word (address 1), holding the address for a programmable settle time before each sample. It compares both words against build-time expected values and publishes pass/fail flags, the captured words and a saturating mismatch counter. It sits between the sysid slave and the board-level status/LED logic and is the slave's only master.

## Interface

Parameters:
- EXPECTED_ID, 32'd0: value the ID word must equal.
- EXPECTED_TS, 32'd1530840655: value the timestamp word must equal.
- SETTLE_CYCLES, 1: extra cycles the address is held before readdata is sampled. Legal range 0..15.
- AUTO_START, 1: when 1, one check runs automatically after reset.

Ports:
- clock, in, 1: single system clock; all logic is on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle request to run a check. Sampled only in IDLE or DONE.
- sysid_address, out, 1: address to the sysid slave (0 = ID, 1 = timestamp).
- sysid_read, out, 1: high while an address is being driven for sampling.
- sysid_readdata, in, 32: combinational read data from the sysid slave.
- busy, out, 1: high in RD_ID, RD_TS and CHECK.
- done, out, 1: level; high in DONE until the next accepted start or reset.
- id_ok, out, 1: ID matched on the last completed check.
- ts_ok, out, 1: timestamp matched on the last completed check.
- id_value, out, 32: ID word captured on the last check.
- ts_value, out, 32: timestamp word captured on the last check.
- mismatch_count, out, 8: number of failed checks since reset; saturates at 255.

## Operation

- States: IDLE, RD_ID, RD_TS, CHECK, DONE.
- IDLE → RD_ID when start = 1, or when the auto_pending flag is set.
  - auto_pending is set by reset when AUTO_START = 1 and cleared on entry to RD_ID.
- RD_ID:
  - sysid_address = 0, sysid_read = 1.
  - Settle counter runs 0..SETTLE_CYCLES.
  - On the cycle the counter equals SETTLE_CYCLES: capture id_value ← sysid_readdata, then go to RD_TS.
- RD_TS: same as RD_ID with sysid_address = 1; captures ts_value, then goes to CHECK.
- CHECK (1 cycle):
  - id_ok ← (id_value == EXPECTED_ID).
  - ts_ok ← (ts_value == EXPECTED_TS).
  - If either compare fails and mismatch_count < 255, mismatch_count increments by 1.
  - Then go to DONE.
- DONE → RD_ID on start = 1. id_ok and ts_ok are cleared in the same cycle; id_value and ts_value keep their old values until recaptured.
- start in RD_ID, RD_TS or CHECK is ignored and is not queued.
- Outside RD_ID and RD_TS: sysid_read = 0 and sysid_address = 0.
- Comparisons are 32-bit unsigned equality. The counter is 4 bits and is cleared on every state entry.

## Timing

- Reset values:
  - State IDLE.
  - All outputs 0, including id_value, ts_value and mismatch_count.
  - auto_pending = AUTO_START.
- Cycle 0 is the first cycle with reset low. With AUTO_START = 1 the state is RD_ID in cycle 1.
- Check duration:
  - RD_ID and RD_TS each last SETTLE_CYCLES + 1 cycles. CHECK lasts 1 cycle.
  - Start pulse in cycle N → done = 1 from cycle N + 2·(SETTLE_CYCLES + 1) + 2.
  - SETTLE_CYCLES = 1: done is high at N + 6. SETTLE_CYCLES = 0: done is high at N + 4.
- id_ok and ts_ok become valid in the same cycle done rises.
- busy and done are never high together. busy falls in the same cycle done rises.
- Reset asserted mid-check: in the next cycle the block is in IDLE with reset values, and mismatch_count is cleared. With AUTO_START = 1 it re-runs.
- start and reset high together: reset wins.

## Structure

- Shared package sysid_check_pkg holds:
  - the state encoding (3-bit, 5 states);
  - the address constants SYSID_ADDR_ID = 0 and SYSID_ADDR_TS = 1;
  - the mismatch counter width (8) and settle counter width (4).
- One natural sub-module, sysid_settle_timer: 4-bit counter with clear/enable inputs and an expired output (count == SETTLE_CYCLES).
- Top level holds the FSM, the capture registers, the compare logic and the saturating counter.

## Test plan

- Reset release, AUTO_START = 1, SETTLE_CYCLES = 1, model slave returning 0 / 1530840655:
  - → sysid_address 0 in cycles 1–2 and 1 in cycles 3–4;
  - → done = 1, id_ok = ts_ok = 1 and mismatch_count = 0 at cycle 6.
- Model timestamp changed to 32'h12345678, start pulse:
  - → ts_ok = 0, id_ok = 1, ts_value = 32'h12345678, mismatch_count = 1.
- start asserted in every cycle while busy → exactly one check completes; done rises once at N + 6.
- 260 failing checks in a row → mismatch_count stops at 255.
- Reset pulsed while in RD_TS:
  - → all outputs return to 0 one cycle later;
  - → the auto check re-runs and finishes 6 cycles after reset deassertion.
- SETTLE_CYCLES = 0 and SETTLE_CYCLES = 15:
  - → done at N + 4 and N + 34 respectively;
  - → readdata is sampled only on the final cycle of each read phase (checked by changing the model's data on earlier cycles of the phase).
